pipe_hazard_ctrl: RTL

//  Central stall/flush/interrupt sequencer for the 5-stage pipelined OTTER. Detects load-use hazards

---
 rtl/cpu_types.sv | 40 ++++
 rtl/intr_sync.sv | 26 ++
 rtl/pipe_hazard_ctrl.sv | 137 +++++++++++++
 3 files changed

// File: rtl/cpu_types.sv
// Shared OTTER pipeline types: pipeline control state, NOP bubble, hazard helpers.
package cpu_types;

  typedef enum logic [1:0] {
    PC_RUN,
    PC_DRAIN,
    PC_TAKE
  } pipe_state_t;

  typedef logic [31:0] instr_t;

  // All-zero word: opcode 7'b0, every write/mem enable decodes to 0
  localparam instr_t NOP_BUBBLE = 32'h0000_0000;

  typedef struct packed {
    logic pc_stall;
    logic if_id_stall;
    logic de_ex_bubble;
    logic if_id_flush;
    logic int_taken;
  } hz_ctrl_t;

  localparam hz_ctrl_t HZ_IDLE = '0;

  function automatic logic ld_use(
    input logic       memread,
    input logic [4:0] rd,
    input logic [4:0] rs1,
    input logic [4:0] rs2,
    input logic       rs1_used,
    input logic       rs2_used
  );
    logic hit1;
    logic hit2;
    hit1 = rs1_used && (rs1 == rd);
    hit2 = rs2_used && (rs2 == rd);
    return memread && (rd != 5'd0) && (hit1 || hit2);
  endfunction

endpackage

// File: rtl/intr_sync.sv
// Multi-flop synchronizer for the async INTR level with rising-edge pulse.
module intr_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic async_i,
  output logic rise_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise_o = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// OTTER stall/flush/interrupt sequencer: load-use stalls, branch flushes,
// pipeline drain before trap entry, and debug event counters.
module pipe_hazard_ctrl
  import cpu_types::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 32
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [4:0]       DE_RS1_ADDR,
  input  logic [4:0]       DE_RS2_ADDR,
  input  logic             DE_RS1_USED,
  input  logic             DE_RS2_USED,
  input  logic             EX_MEMREAD,
  input  logic [4:0]       EX_RD_ADDR,
  input  logic             EX_JB_TAKEN,
  input  logic             INTR,
  input  logic             MIE,
  output logic             PC_STALL,
  output logic             IF_ID_STALL,
  output logic             DE_EX_BUBBLE,
  output logic             IF_ID_FLUSH,
  output logic             INT_TAKEN,
  output logic [CNT_W-1:0] STALL_CNT,
  output logic [CNT_W-1:0] FLUSH_CNT
);

  localparam int DCW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DCW-1:0] DRAIN_LAST = DCW'(DRAIN_CYCLES - 1);

  pipe_state_t      state_q, state_d;
  logic [DCW-1:0]   cnt_q, cnt_d;
  logic             pend_q, pend_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  hz_ctrl_t         ctl;
  logic             intr_rise;
  logic             ld_haz;

  intr_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_intr_sync (
    .clk_i  (CLK),
    .rst_i  (RESET),
    .async_i(INTR),
    .rise_o (intr_rise)
  );

  assign ld_haz = ld_use(EX_MEMREAD, EX_RD_ADDR,
                         DE_RS1_ADDR, DE_RS2_ADDR,
                         DE_RS1_USED, DE_RS2_USED);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= PC_RUN;
      cnt_q       <= '0;
      pend_q      <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pend_d      = pend_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    ctl         = HZ_IDLE;

    // Edges seen once a trap is already in flight merge into it
    if (intr_rise && (state_q == PC_RUN)) begin
      pend_d = 1'b1;
    end

    unique case (state_q)
      PC_RUN: begin
        if (EX_JB_TAKEN) begin
          ctl.if_id_flush  = 1'b1;
          ctl.de_ex_bubble = 1'b1;
          flush_cnt_d      = flush_cnt_q + CNT_W'(1);
        end else if (ld_haz) begin
          ctl.pc_stall     = 1'b1;
          ctl.if_id_stall  = 1'b1;
          ctl.de_ex_bubble = 1'b1;
          stall_cnt_d      = stall_cnt_q + CNT_W'(1);
        end else if (pend_q && MIE) begin
          state_d = PC_DRAIN;
          cnt_d   = '0;
        end
      end
      PC_DRAIN: begin
        ctl.pc_stall     = 1'b1;
        ctl.if_id_stall  = 1'b1;
        ctl.de_ex_bubble = 1'b1;
        // An older branch retiring still redirects fetch
        if (EX_JB_TAKEN) begin
          ctl.pc_stall    = 1'b0;
          ctl.if_id_flush = 1'b1;
          flush_cnt_d     = flush_cnt_q + CNT_W'(1);
        end
        if (cnt_q == DRAIN_LAST) begin
          state_d = PC_TAKE;
        end else begin
          cnt_d = cnt_q + DCW'(1);
        end
      end
      PC_TAKE: begin
        ctl.int_taken    = 1'b1;
        ctl.if_id_flush  = 1'b1;
        ctl.de_ex_bubble = 1'b1;
        pend_d           = 1'b0;
        state_d          = PC_RUN;
      end
      default: begin
        state_d = PC_RUN;
      end
    endcase
  end

  assign PC_STALL     = ctl.pc_stall     & ~RESET;
  assign IF_ID_STALL  = ctl.if_id_stall  & ~RESET;
  assign DE_EX_BUBBLE = ctl.de_ex_bubble & ~RESET;
  assign IF_ID_FLUSH  = ctl.if_id_flush  & ~RESET;
  assign INT_TAKEN    = ctl.int_taken    & ~RESET;
  assign STALL_CNT    = stall_cnt_q;
  assign FLUSH_CNT    = flush_cnt_q;

endmodule
